// File: rtl/shift_counter_pkg.sv
// Shared mode encodings and helpers for the shift_counter block.
package shift_counter_pkg;

  localparam logic [2:0] MODE_HOLD    = 3'd0;
  localparam logic [2:0] MODE_SHR     = 3'd1;
  localparam logic [2:0] MODE_SHL     = 3'd2;
  localparam logic [2:0] MODE_LOAD    = 3'd3;
  localparam logic [2:0] MODE_RING    = 3'd4;
  localparam logic [2:0] MODE_JOHNSON = 3'd5;
  localparam logic [2:0] MODE_CLEAR   = 3'd6;

  localparam int unsigned MAX_WIDTH = 64;

  // Only the low `width` bits are inspected, so zero padding above them adds no transitions.
  function automatic logic johnson_legal(input logic [MAX_WIDTH-1:0] data,
                                         input int unsigned width = MAX_WIDTH);
    int unsigned trans;
    trans = 0;
    for (int unsigned i = 0; i + 1 < MAX_WIDTH; i++) begin
      if ((i + 1 < width) && (data[i] != data[i+1])) trans++;
    end
    return (trans <= 1);
  endfunction

endpackage

// File: rtl/shift_period_ctr.sv
// Period counter for ring/Johnson sequences; pulses wrap for one cycle per completed period.
module shift_period_ctr #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(2 * WIDTH)
) (
  input  logic clkIn,
  input  logic rst,
  input  logic step,
  input  logic is_johnson,
  input  logic clear,
  output logic wrap
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_idx;
  logic          last_cm_q, last_cm_d;
  logic          wrap_q, wrap_d;

  always_comb begin
    cnt_d     = cnt_q;
    last_cm_d = last_cm_q;
    wrap_d    = 1'b0;
    last_idx  = is_johnson ? CW'(2 * WIDTH - 1) : CW'(WIDTH - 1);
    if (clear) begin
      cnt_d     = '0;
      last_cm_d = 1'b0;
    end else if (step) begin
      // A change of sequence type restarts the phase with this step as the first one.
      if (is_johnson != last_cm_q) begin
        cnt_d     = CW'(1);
        last_cm_d = is_johnson;
      end else if (cnt_q == last_idx) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      last_cm_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      last_cm_q <= last_cm_d;
      wrap_q    <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: rtl/shift_counter.sv
// Multi-mode shift register / ring / Johnson counter with period wrap flag.
// Define SHREG_SELFCORRECT_EN to recover illegal ring and Johnson states.
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int unsigned      CW    = $clog2(2 * WIDTH)
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             din,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] data,
  output logic             dout,
  output logic             wrap
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             dout_q, dout_d;
  logic             step, is_johnson, ctr_clear;
  logic             fix_ring, fix_john;

`ifdef SHREG_SELFCORRECT_EN
  assign fix_ring = (data_q == '0);
  assign fix_john = !johnson_legal(MAX_WIDTH'(data_q), WIDTH);
`else
  assign fix_ring = 1'b0;
  assign fix_john = 1'b0;
`endif

  always_comb begin
    data_d     = data_q;
    dout_d     = dout_q;
    step       = 1'b0;
    is_johnson = 1'b0;
    ctr_clear  = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHR: begin
          data_d    = {din, data_q[WIDTH-1:1]};
          dout_d    = data_q[0];
          ctr_clear = 1'b1;
        end
        MODE_SHL: begin
          data_d    = {data_q[WIDTH-2:0], din};
          dout_d    = data_q[WIDTH-1];
          ctr_clear = 1'b1;
        end
        MODE_LOAD: begin
          data_d    = pin;
          ctr_clear = 1'b1;
        end
        MODE_RING: begin
          dout_d = data_q[0];
          if (fix_ring) begin
            data_d    = {1'b1, {(WIDTH - 1){1'b0}}};
            ctr_clear = 1'b1;
          end else begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
            step   = 1'b1;
          end
        end
        MODE_JOHNSON: begin
          dout_d     = data_q[0];
          is_johnson = 1'b1;
          if (fix_john) begin
            data_d    = '0;
            ctr_clear = 1'b1;
          end else begin
            data_d = {~data_q[0], data_q[WIDTH-1:1]};
            step   = 1'b1;
          end
        end
        MODE_CLEAR: begin
          data_d    = '0;
          dout_d    = 1'b0;
          ctr_clear = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      data_q <= INIT;
      dout_q <= 1'b0;
    end else begin
      data_q <= data_d;
      dout_q <= dout_d;
    end
  end

  shift_period_ctr #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_period (
    .clkIn      (clkIn),
    .rst        (rst),
    .step       (step),
    .is_johnson (is_johnson),
    .clear      (ctr_clear),
    .wrap       (wrap)
  );

  assign data = data_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_shift_counter.sv
// Self-checking bench for shift_counter (WIDTH = 4) against an arithmetic reference model.
module tb_shift_counter;

  localparam int W = 4;

  logic         clkIn;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic         din;
  logic [W-1:0] pin;
  logic [W-1:0] data;
  logic         dout;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  // Reference state: register value as an integer, plus the current same-type run length.
  int m_data, m_dout, m_wrap;
  int run_kind, run_len;

  shift_counter #(
    .WIDTH (W)
  ) dut (
    .clkIn (clkIn),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .din   (din),
    .pin   (pin),
    .data  (data),
    .dout  (dout),
    .wrap  (wrap)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sc_fix(input int kind, input int v);
    int t;
    t = 0;
`ifdef SHREG_SELFCORRECT_EN
    if (kind == 0) return (v == 0);
    for (int i = 0; i < W - 1; i++) if (((v >> i) & 1) != ((v >> (i + 1)) & 1)) t++;
    return (t > 1);
`else
    return (t != 0) && (kind < 0);
`endif
  endfunction

  task automatic model_reset();
    m_data = 0; m_dout = 0; m_wrap = 0; run_kind = 0; run_len = 0;
  endtask

  task automatic model_step(input int e, input int md, input int d, input int p);
    int old, kind, w;
    old = m_data;
    w = 0;
    if (e != 0) begin
      case (md)
        1: begin m_data = (old >> 1) + d * 8;     m_dout = old % 2; run_kind = 0; run_len = 0; end
        2: begin m_data = (old * 2) % 16 + d;     m_dout = old / 8; run_kind = 0; run_len = 0; end
        3: begin m_data = p;                                        run_kind = 0; run_len = 0; end
        6: begin m_data = 0;                      m_dout = 0;       run_kind = 0; run_len = 0; end
        4, 5: begin
          kind = md - 4;
          m_dout = old % 2;
          if (sc_fix(kind, old)) begin
            m_data = (kind == 1) ? 0 : 8;
            run_kind = kind;
            run_len = 0;
          end else begin
            m_data = (kind == 0) ? (old >> 1) + (old % 2) * 8 : (old >> 1) + (1 - old % 2) * 8;
            if (kind != run_kind) begin
              run_kind = kind;
              run_len = 1;
            end else begin
              run_len++;
            end
            w = ((run_len % ((kind == 1) ? 2 * W : W)) == 0) ? 1 : 0;
          end
        end
        default: ;
      endcase
    end
    m_wrap = w;
  endtask

  task automatic do_step(input int e, input int md, input int d, input int p, input string tag);
    en   = 1'(e);
    mode = 3'(md);
    din  = 1'(d);
    pin  = W'(p);
    model_step(e, md, d, p);
    @(posedge clkIn);
    #1;
    chk({tag, ".data"}, 32'(data), 32'(m_data));
    chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    int md, prev_md;
    rst = 1'b1; en = 1'b0; mode = 3'd0; din = 1'b0; pin = '0;
    model_reset();
    #12;
    chk("reset.data", 32'(data), 32'(m_data));
    chk("reset.dout", 32'(dout), 32'(m_dout));
    chk("reset.wrap", 32'(wrap), 32'(m_wrap));
    @(negedge clkIn);
    rst = 1'b0;

    // Serial shift right: 1000, 0100, 1010, 1101, then 0110 with dout 1.
    do_step(1, 1, 1, 0, "shr1");
    do_step(1, 1, 0, 0, "shr2");
    do_step(1, 1, 1, 0, "shr3");
    do_step(1, 1, 1, 0, "shr4");
    do_step(1, 1, 0, 0, "shr5");
    chk("shr5.lit", 32'(data), 32'h6);

    // Ring from a one-hot seed: wrap only after the 4th step.
    do_step(1, 3, 0, 8, "load8");
    for (int i = 0; i < 4; i++) do_step(1, 4, 0, 0, "ring");
    chk("ring.lit", 32'(wrap), 32'h1);
    do_step(1, 0, 0, 0, "hold");

    // Johnson from zero: full period of eight steps.
    do_step(1, 6, 0, 0, "clear");
    for (int i = 0; i < 8; i++) do_step(1, 5, 0, 0, "john");
    chk("john.lit", 32'(wrap), 32'h1);

    // Shift left after a parallel load, with en dropped mid-sequence.
    do_step(1, 3, 0, 6, "load6");
    do_step(1, 2, 1, 0, "shl");
    chk("shl.lit", 32'(data), 32'hd);
    do_step(0, 2, 1, 0, "enlo1");
    do_step(0, 4, 0, 5, "enlo2");
    do_step(1, 7, 1, 3, "mode7");

    // Random walk with sticky modes so ring/Johnson runs are long enough to wrap.
    prev_md = 4;
    for (int i = 0; i < 400; i++) begin
      md = ($urandom_range(0, 9) < 7) ? prev_md : int'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) md = ($urandom_range(0, 1) == 0) ? 3 : 6;
      prev_md = md;
      do_step(($urandom_range(0, 7) != 0) ? 1 : 0, md, int'($urandom_range(0, 1)),
              (md == 3 && $urandom_range(0, 1) == 0) ? 8 : int'($urandom_range(0, 15)), "rnd");
    end

    // Asynchronous reset between edges while wrap is high.
    do_step(1, 3, 0, 8, "preload");
    for (int i = 0; i < 4; i++) do_step(1, 4, 0, 0, "prering");
    chk("prereset.wrap", 32'(wrap), 32'h1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async.data", 32'(data), 32'(m_data));
    chk("async.dout", 32'(dout), 32'(m_dout));
    chk("async.wrap", 32'(wrap), 32'(m_wrap));
    @(negedge clkIn);
    rst = 1'b0;
    do_step(1, 4, 0, 0, "postreset");
`ifdef SHREG_SELFCORRECT_EN
    chk("postreset.lit", 32'(data), 32'h8);
`else
    chk("postreset.lit", 32'(data), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_counter.md
Name: shift_counter

Overview:
- Parametrised multi-mode shift register and counter block, the successor to the fixed 4-bit serial-in right shifter.
- One register implements serial shift right and left, parallel load, clear, ring counter and Johnson counter, selected at run time by `mode`.
- A period counter flags when a ring or Johnson sequence completes a full cycle.
- Used as the shared building block for serial links and sequence generators.

Parameters:
- WIDTH, 4, register width in bits; legal range is WIDTH >= 2.
- INIT, {WIDTH{1'b0}}, value loaded into `data` on reset.
- CW, $clog2(2*WIDTH), width of the internal period counter. Derived; do not override.

Ports:
- clkIn  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  step enable; when low, all state holds.
- mode  input  3  operation select (encoding in Behaviour).
- din  input  1  serial data in.
- pin  input  WIDTH  parallel load data.
- data  output  WIDTH  register contents (registered).
- dout  output  1  last bit shifted out (registered).
- wrap  output  1  one-cycle pulse on completion of a ring or Johnson period.

Behaviour:
- Reset is asynchronous and active-high:
  - `data` = INIT, `dout` = 0, `wrap` = 0, period counter = 0, `last_cm` = 0.
- Mode encoding:
  - 0 HOLD
  - 1 SHR
  - 2 SHL
  - 3 LOAD
  - 4 RING
  - 5 JOHNSON
  - 6 CLEAR
  - 7 reserved; behaves as HOLD.
- en = 0: `data`, `dout` and the counter hold; `wrap` <= 0.
- en = 1, per mode (all single-cycle, latency 1 clock):
  - SHR: `data` <= {din, data[WIDTH-1:1]}; `dout` <= data[0].
  - SHL: `data` <= {data[WIDTH-2:0], din}; `dout` <= data[WIDTH-1].
  - LOAD: `data` <= pin; `dout` holds.
  - RING: `data` <= {data[0], data[WIDTH-1:1]}; `dout` <= data[0].
  - JOHNSON: `data` <= {~data[0], data[WIDTH-1:1]}; `dout` <= data[0].
  - CLEAR: `data` <= 0; `dout` <= 0.
  - HOLD / 7: no change.
- Period counter (CW bits) and `last_cm` (1 bit: 0 = ring, 1 = Johnson):
  - Cleared by LOAD, CLEAR, SHR and SHL steps.
  - Not affected by HOLD, mode 7 or en = 0.
  - A RING or JOHNSON step whose type differs from `last_cm`: counter <= 1, `last_cm` updated, `wrap` <= 0.
  - Otherwise, a step with counter == P-1 sets `wrap` <= 1 and counter <= 0.
    - P = WIDTH for RING; P = 2*WIDTH for JOHNSON.
  - Otherwise the counter increments and `wrap` <= 0.
- `wrap` is high for exactly one cycle, in the cycle after the completing step. It is 0 in every non-wrap cycle.
- Period phase is counted from the first step after entry. It is not pattern-matched, so `wrap` is meaningful only after a LOAD or CLEAR with a legal seed.
- The first ring/Johnson step after reset counts as a mode-type change only if Johnson is selected. The first RING step after reset continues from counter = 0.
- Reset mid-operation aborts immediately; no partial shift is retained.
- din and pin are ignored in modes that do not use them.

Optional Feature:
- Macro: SHREG_SELFCORRECT_EN.
- When defined:
  - A RING step with `data` == 0 loads {1'b1, {WIDTH-1{1'b0}}} instead of rotating.
  - A JOHNSON step where `data` has more than one adjacent-bit transition loads 0 instead of shifting.
  - In both cases the counter resets to 0 and `wrap` <= 0.
- When undefined: illegal states circulate unchanged; the rotation and shift rules above apply verbatim.

Decomposition:
- Shared package `shift_counter_pkg`:
  - localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_RING, MODE_JOHNSON, MODE_CLEAR.
  - Function `johnson_legal(data)` (transition count <= 1).
- Sub-module `shift_period_ctr`:
  - Contains the period counter and `wrap` logic.
  - Inputs: step, is_johnson, clear. Output: wrap.
  - Keeps the datapath free of counting logic.

Test Plan:
- WIDTH = 4. Reset, then SHR with din sequence 1,0,1,1 -> `data` 1000, 0100, 1010, 1101; `dout` 0,0,0,0.
  - One further SHR with din = 0 -> `data` 0110, `dout` 1.
- LOAD pin = 1000, then 4 RING steps -> 0100, 0010, 0001, 1000; `wrap` high only in the cycle after the 4th step.
- CLEAR, then 8 JOHNSON steps -> 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; `wrap` once, after step 8.
- SHL pin load 0110 with din = 1 -> `data` 1101, `dout` 0. Toggle `en` low mid-sequence -> no change, `wrap` = 0.
- Assert `rst` asynchronously between edges during RING -> `data` = INIT, `dout` = 0 and `wrap` = 0 immediately. First RING step after release: 0000 -> 0000.
  - With SHREG_SELFCORRECT_EN defined: 0000 -> 1000 instead.
